data_mem_port: RTL and testbench
================================

# data_mem_port

Parametrised, byte-addressed, big-endian data memory with a request/valid handshake, byte/half/word access sizes, sign/zero-extended loads, alignment and range fault detection, and configurable wait states. It replaces the fixed 512-byte, word-only, combinational-read data memory, and sits between the CPU's memory stage and the on-chip RAM. Its purpose is to support multicycle and pipelined datapaths and narrow loads and stores.

## Interface
- DEPTH_BYTES, 512: memory size in bytes; any value ≥ 4, not necessarily a power of two.
- WAIT_CYCLES, 0: extra cycles between request acceptance and response, in the range 0..15.
- CLK  in  1  the only clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- Req  in  1  request; accepted on a rising edge when Req=1 and Ready=1.
- WE  in  1  1 = store, 0 = load.
- Size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (faults).
- Unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- DAddr  in  32  byte address.
- DataIn  in  32  store data; valid data is right-aligned.
- Ready  out  1  block can accept a request.
- Valid  out  1  one-cycle pulse marking the response for the accepted request.
- DataOut  out  32  load result; 0 for stores and faulted accesses.
- Fault  out  1  qualified by Valid; the access was misaligned, out of range, or used Size=11.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE: Ready=1. On acceptance, latch WE, Size, Unsigned, DAddr and DataIn.
  - If WAIT_CYCLES=0, go to RESP.
  - Otherwise go to WAIT and load the counter with WAIT_CYCLES-1.
- WAIT: Ready=0. The counter decrements each cycle. When the counter is 0, go to RESP on the next edge.
- RESP: Ready=0 and Valid=1 for exactly one cycle, then return to IDLE. Req is ignored in WAIT and RESP.
- The memory access is performed on the edge that enters RESP. Write strobes and the DataOut register update on that same edge.
- Fault conditions, evaluated on the latched request:
  - Size=11.
  - Half access with DAddr[0]≠0.
  - Word access with DAddr[1:0]≠0.
  - DAddr + nbytes > DEPTH_BYTES, compared at the full 33-bit width. Addresses never wrap.
- A faulted access writes no byte, returns DataOut=0 and sets Fault=1. Its latency is identical to a good access.
- Byte ordering is big-endian: the byte at DAddr is the most significant byte.
  - Store byte: DataIn[7:0] → [A].
  - Store half: DataIn[15:8] → [A], DataIn[7:0] → [A+1].
  - Store word: DataIn[31:24] → [A] through DataIn[7:0] → [A+3].
- Loads return the value right-aligned. The upper bits are sign- or zero-extended according to Unsigned. Unsigned is ignored for word loads.
- A store never partially completes: either all of its bytes are written at one edge, or none are.

## Timing
- Latency from the acceptance edge to Valid high is WAIT_CYCLES+1 cycles.
- Throughput is one request per WAIT_CYCLES+2 cycles.
- Reset values: state=IDLE, Ready=1, Valid=0, Fault=0, DataOut=0, counter=0.
- Reset does not clear the memory array.
- Reset asserted during WAIT aborts the request: no write occurs and no Valid is issued. Reset asserted during RESP completes that cycle's already-performed write, but Valid drops immediately.
- A Req held high through RESP is re-accepted in the following IDLE cycle.

## Structure
- Package data_mem_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD and SZ_RSVD;
  - the state enum mem_state_t with IDLE, WAIT and RESP.
- Sub-module data_mem_array is the byte array, parametrised by DEPTH_BYTES. It has four byte-lane write ports with strobes, takes a base address and provides a 4-byte big-endian read.
- data_mem_port contains the FSM, the wait counter, the fault checks, lane steering and load extension.

## Test plan
- WAIT_CYCLES=0: store word 0x12345678 to address 8, then load word from address 8. Expect DataOut=0x12345678, Fault=0, with Valid one cycle after each acceptance. Then byte loads from 8..11 return 0x12, 0x34, 0x56, 0x78.
- Store byte 0x80 to address 20, then signed load byte from 20 → 0xFFFFFF80. Unsigned load byte from 20 → 0x00000080. Store half 0xBEEF to address 22, then signed load half from 22 → 0xFFFFBEEF.
- Misaligned accesses: load half from address 3 and store word to address 6 both give Fault=1 and DataOut=0. The later word load from address 4 shows bytes 4..7 unchanged.
- DEPTH_BYTES=512: word load from address 508 gives Fault=0. Word load from 510 faults for misalignment. Half load from 512 faults for range. Word load from 0xFFFFFFFC faults with no wrap.
- WAIT_CYCLES=3: Valid appears exactly 4 cycles after acceptance, and Ready stays low for 4 cycles. A back-to-back Req held high is accepted every 5 cycles.
- WAIT_CYCLES=3: store 0xAAAAAAAA to address 0, then pulse RST_N low during WAIT. No Valid is issued, Ready=1 after reset, and a subsequent load from address 0 returns the pre-store contents.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory port: access sizes and FSM states.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Reserved size reports 4 so the range check stays well defined; it faults anyway.
    function automatic logic [2:0] size_nbytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-wide RAM with four write lanes; lane k addresses base+k, lane 0 is the most significant byte.
module data_mem_array #(
    parameter int DEPTH_BYTES = 512
) (
    input  logic        CLK,
    input  logic [3:0]  we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    logic [7:0]  mem_q [DEPTH_BYTES];
    logic [32:0] lane_addr [4];
    logic [3:0]  lane_ok;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign lane_addr[k] = {1'b0, addr_i} + 33'(k);
        assign lane_ok[k]   = lane_addr[k] < 33'(DEPTH_BYTES);
        assign rdata_o[31-8*k -: 8] = lane_ok[k] ? mem_q[lane_addr[k][AW-1:0]] : 8'h00;
    end

    // No reset: contents survive RST_N.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[k] && lane_ok[k])
                mem_q[lane_addr[k][AW-1:0]] <= wdata_i[31-8*k -: 8];
        end
    end

endmodule

// File: rtl/data_mem_port.sv
// Request/valid data memory port: wait-state FSM, fault checks, big-endian lane steering, load extension.
module data_mem_port
    import data_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Req,
    input  logic        WE,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    output logic        Ready,
    output logic        Valid,
    output logic [31:0] DataOut,
    output logic        Fault
);
    mem_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, din_q;
    logic [31:0] dout_q, dout_d;
    logic        fault_q, fault_d;

    logic        accept, go_resp;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_din;
    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    logic [3:0]  lane_mask, wstb;
    logic [31:0] wdata, rdata, load_val;

    assign accept = (state_q == IDLE) && Req;

    // With no wait states the access happens on the acceptance edge, so use the live request.
    assign r_we   = (state_q == IDLE) ? WE       : we_q;
    assign r_uns  = (state_q == IDLE) ? Unsigned : uns_q;
    assign r_size = (state_q == IDLE) ? Size     : size_q;
    assign r_addr = (state_q == IDLE) ? DAddr    : addr_q;
    assign r_din  = (state_q == IDLE) ? DataIn   : din_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (Req) begin
                if (WAIT_CYCLES == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                end
            end
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
                  else               cnt_d   = cnt_q - 4'd1;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign go_resp = (state_d == RESP);

    assign nbytes   = size_nbytes(r_size);
    assign end_addr = {1'b0, r_addr} + {30'b0, nbytes};
    assign fault_d  = (r_size == SZ_RSVD)
                   || (r_size == SZ_HALF && r_addr[0])
                   || (r_size == SZ_WORD && r_addr[1:0] != 2'b00)
                   || (end_addr > 33'(DEPTH_BYTES));

    always_comb begin
        wdata     = r_din;
        lane_mask = 4'b1111;
        load_val  = rdata;
        case (r_size)
            SZ_BYTE: begin
                wdata     = {r_din[7:0], 24'h0};
                lane_mask = 4'b0001;
                load_val  = {{24{~r_uns & rdata[31]}}, rdata[31:24]};
            end
            SZ_HALF: begin
                wdata     = {r_din[15:0], 16'h0};
                lane_mask = 4'b0011;
                load_val  = {{16{~r_uns & rdata[31]}}, rdata[31:16]};
            end
            default: ;
        endcase
    end

    assign wstb   = (go_resp && r_we && !fault_d) ? lane_mask : 4'b0000;
    assign dout_d = (r_we || fault_d) ? 32'h0 : load_val;

    data_mem_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
        .CLK     (CLK),
        .we_i    (wstb),
        .addr_i  (r_addr),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= 32'h0;
            din_q   <= 32'h0;
            dout_q  <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q   <= WE;
                uns_q  <= Unsigned;
                size_q <= Size;
                addr_q <= DAddr;
                din_q  <= DataIn;
            end
            if (go_resp) begin
                dout_q  <= dout_d;
                fault_q <= fault_d;
            end
        end
    end

    assign Ready   = (state_q == IDLE);
    assign Valid   = (state_q == RESP);
    assign DataOut = dout_q;
    assign Fault   = fault_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Bench for data_mem_port: two instances (0 and 3 wait states) checked against a byte-array model.
module tb_data_mem_port;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req [2], we [2], uns [2];
    logic [1:0]  sz [2];
    logic [31:0] addr [2], din [2];
    logic        rdy [2], vld [2], flt [2];
    logic [31:0] dout [2];

    int checks = 0;
    int failures = 0;
    logic [7:0] mdl [2][DEPTH];

    data_mem_port #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .Req(req[0]), .WE(we[0]), .Size(sz[0]), .Unsigned(uns[0]),
        .DAddr(addr[0]), .DataIn(din[0]), .Ready(rdy[0]), .Valid(vld[0]), .DataOut(dout[0]), .Fault(flt[0]));

    data_mem_port #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .CLK(clk), .RST_N(rst_n), .Req(req[1]), .WE(we[1]), .Size(sz[1]), .Unsigned(uns[1]),
        .DAddr(addr[1]), .DataIn(din[1]), .Ready(rdy[1]), .Valid(vld[1]), .DataOut(dout[1]), .Fault(flt[1]));

    // Reference: big-endian byte array, fault rules evaluated with 64-bit arithmetic.
    function automatic void ref_op(input int s, input bit w, input logic [1:0] z, input bit u,
                                   input logic [31:0] a, input logic [31:0] d,
                                   output logic [31:0] ed, output logic ef);
        int n;
        longint ea;
        logic [31:0] v;
        n  = (z == 2'b00) ? 1 : (z == 2'b01) ? 2 : 4;
        ea = {32'h0, a};
        ef = (z == 2'b11) || ((ea % n) != 0) || (ea + n > DEPTH);
        ed = 32'h0;
        if (ef) return;
        if (w) begin
            for (int k = 0; k < n; k++) mdl[s][ea + k] = 8'((d >> (8 * (n - 1 - k))) & 32'hFF);
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = (v << 8) | {24'h0, mdl[s][ea + k]};
            if (!u && n == 1 && v[7])  v = v | 32'hFFFFFF00;
            if (!u && n == 2 && v[15]) v = v | 32'hFFFF0000;
            ed = v;
        end
    endfunction

    task automatic xact(input int s, input bit w, input logic [1:0] z, input bit u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] od, output logic of, output int lat);
        @(negedge clk);
        checks++;
        if (rdy[s] !== 1'b1) begin
            failures++;
            $display("FAIL ready_idle dut%0d ready=%b required=1", s, rdy[s]);
        end
        req[s] = 1'b1; we[s] = w; sz[s] = z; uns[s] = u; addr[s] = a; din[s] = d;
        @(negedge clk);
        req[s] = 1'b0;
        lat = 1;
        while (vld[s] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        od = dout[s];
        of = flt[s];
    endtask

    task automatic op(input int s, input bit w, input logic [1:0] z, input bit u,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] gd, output logic gf,
                      output logic [31:0] ed, output logic ef, output int lat);
        xact(s, w, z, u, a, d, gd, gf, lat);
        ref_op(s, w, z, u, a, d, ed, ef);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            req[s] = 0; we[s] = 0; sz[s] = 0; uns[s] = 0; addr[s] = 0; din[s] = 0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks += 4;
            if (rdy[s] !== 1'b1) begin failures++; $display("FAIL reset_ready dut%0d got=%b exp=1", s, rdy[s]); end
            if (vld[s] !== 1'b0) begin failures++; $display("FAIL reset_valid dut%0d got=%b exp=0", s, vld[s]); end
            if (flt[s] !== 1'b0) begin failures++; $display("FAIL reset_fault dut%0d got=%b exp=0", s, flt[s]); end
            if (dout[s] !== 32'h0) begin failures++; $display("FAIL reset_dout dut%0d got=%h exp=0", s, dout[s]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic fill_memory();
        logic [31:0] gd, ed; logic gf, ef; int lat;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < DEPTH; a += 4) begin
                op(s, 1'b1, 2'b10, 1'b0, 32'(a), $urandom, gd, gf, ed, ef, lat);
                checks++;
                if (gf !== 1'b0 || gd !== 32'h0) begin
                    failures++;
                    $display("FAIL fill_store dut%0d addr=%0d fault=%b dout=%h exp fault=0 dout=0", s, a, gf, gd);
                end
            end
    endtask

    task automatic test_word_byte();
        logic [31:0] gd, ed; logic gf, ef; int lat;
        logic [7:0] exp_b [4];
        exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
        op(0, 1'b1, 2'b10, 1'b0, 32'd8, 32'h12345678, gd, gf, ed, ef, lat);
        checks++;
        if (gf !== 1'b0 || gd !== 32'h0 || lat != 1) begin
            failures++; $display("FAIL store_word f=%b d=%h lat=%0d exp f=0 d=0 lat=1", gf, gd, lat);
        end
        op(0, 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, gd, gf, ed, ef, lat);
        checks++;
        if (gf !== 1'b0 || gd !== 32'h12345678 || lat != 1) begin
            failures++; $display("FAIL load_word f=%b d=%h lat=%0d exp f=0 d=12345678 lat=1", gf, gd, lat);
        end
        for (int i = 0; i < 4; i++) begin
            op(0, 1'b0, 2'b00, 1'b1, 32'(8 + i), 32'h0, gd, gf, ed, ef, lat);
            checks++;
            if (gf !== 1'b0 || gd !== {24'h0, exp_b[i]}) begin
                failures++; $display("FAIL load_byte addr=%0d f=%b d=%h exp=%h", 8 + i, gf, gd, exp_b[i]);
            end
        end
    endtask

    task automatic test_extension();
        logic [31:0] gd, ed; logic gf, ef; int lat;
        op(0, 1'b1, 2'b00, 1'b0, 32'd20, 32'h00000080, gd, gf, ed, ef, lat);
        op(0, 1'b0, 2'b00, 1'b0, 32'd20, 32'h0, gd, gf, ed, ef, lat);
        checks++;
        if (gd !== 32'hFFFFFF80 || gf !== 1'b0) begin
            failures++; $display("FAIL lb_signed d=%h f=%b exp=ffffff80", gd, gf);
        end
        op(0, 1'b0, 2'b00, 1'b1, 32'd20, 32'h0, gd, gf, ed, ef, lat);
        checks++;
        if (gd !== 32'h00000080) begin
            failures++; $display("FAIL lb_unsigned d=%h exp=00000080", gd);
        end
        op(0, 1'b1, 2'b01, 1'b0, 32'd22, 32'h0000BEEF, gd, gf, ed, ef, lat);
        op(0, 1'b0, 2'b01, 1'b0, 32'd22, 32'h0, gd, gf, ed, ef, lat);
        checks++;
        if (gd !== 32'hFFFFBEEF || gf !== 1'b0) begin
            failures++; $display("FAIL lh_signed d=%h f=%b exp=ffffbeef", gd, gf);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] gd, ed; logic gf, ef; int lat;
        op(0, 1'b0, 2'b01, 1'b0, 32'd3, 32'h0, gd, gf, ed, ef, lat);
        checks++;
        if (gf !== 1'b1 || gd !== 32'h0 || lat != 1) begin
            failures++; $display("FAIL lh_misaligned f=%b d=%h lat=%0d exp f=1 d=0 lat=1", gf, gd, lat);
        end
        op(0, 1'b1, 2'b10, 1'b0, 32'd6, 32'hDEADBEEF, gd, gf, ed, ef, lat);
        checks++;
        if (gf !== 1'b1 || gd !== 32'h0) begin
            failures++; $display("FAIL sw_misaligned f=%b d=%h exp f=1 d=0", gf, gd);
        end
        op(0, 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, gd, gf, ed, ef, lat);
        checks++;
        if (gd !== ed || gf !== 1'b0) begin
            failures++; $display("FAIL bytes4_7_kept d=%h f=%b exp=%h", gd, gf, ed);
        end
    endtask

    task automatic test_range();
        logic [31:0] gd, ed; logic gf, ef; int lat;
        logic [1:0]  t_sz [6];
        logic [31:0] t_a  [6];
        logic        t_f  [6];
        t_sz = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
        t_a  = '{32'd508, 32'd510, 32'd512, 32'hFFFFFFFC, 32'd511, 32'd512};
        t_f  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            op(0, 1'b0, t_sz[i], 1'b1, t_a[i], 32'h0, gd, gf, ed, ef, lat);
            checks++;
            if (gf !== t_f[i] || gd !== ed) begin
                failures++;
                $display("FAIL range size=%0d addr=%h f=%b d=%h exp f=%b d=%h", t_sz[i], t_a[i], gf, gd, t_f[i], ed);
            end
        end
        op(0, 1'b0, 2'b11, 1'b0, 32'd0, 32'h0, gd, gf, ed, ef, lat);
        checks++;
        if (gf !== 1'b1 || gd !== 32'h0) begin
            failures++; $display("FAIL size_rsvd f=%b d=%h exp f=1 d=0", gf, gd);
        end
    endtask

    task automatic test_wait_latency();
        logic [31:0] gd, ed; logic gf, ef; int lat;
        int low, vat;
        op(1, 1'b0, 2'b10, 1'b0, 32'd16, 32'h0, gd, gf, ed, ef, lat);
        checks++;
        if (lat != 4 || gd !== ed || gf !== 1'b0) begin
            failures++; $display("FAIL wait_load lat=%0d d=%h exp lat=4 d=%h", lat, gd, ed);
        end
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; sz[1] = 2'b10; addr[1] = 32'd16;
        @(negedge clk);
        req[1] = 1'b0;
        low = 0; vat = -1;
        for (int i = 1; i <= 6; i++) begin
            if (rdy[1] === 1'b0) low++;
            if (vld[1] === 1'b1) vat = (vat < 0) ? i : 99;
            @(negedge clk);
        end
        checks += 2;
        if (low != 4) begin failures++; $display("FAIL ready_low_cycles got=%0d exp=4", low); end
        if (vat != 4) begin failures++; $display("FAIL valid_cycle got=%0d exp=4", vat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ed; logic ef;
        int acc [$];
        int nv, k;
        logic [31:0] a;
        a = 32'($urandom_range(0, 127) * 4);
        ref_op(1, 1'b0, 2'b10, 1'b0, a, 32'h0, ed, ef);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; sz[1] = 2'b10; uns[1] = 1'b0; addr[1] = a;
        nv = 0;
        for (int i = 0; i < 22; i++) begin
            if (rdy[1] === 1'b1) acc.push_back(i);
            if (vld[1] === 1'b1) begin
                nv++;
                checks++;
                if (dout[1] !== ed) begin failures++; $display("FAIL b2b_data got=%h exp=%h", dout[1], ed); end
            end
            @(negedge clk);
        end
        req[1] = 1'b0;
        checks += 2;
        if (acc.size() != 5) begin failures++; $display("FAIL b2b_accepts got=%0d exp=5", acc.size()); end
        if (nv != 4) begin failures++; $display("FAIL b2b_valids got=%0d exp=4", nv); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 5) begin
                failures++; $display("FAIL b2b_spacing got=%0d exp=5", acc[i] - acc[i-1]);
            end
        end
        k = 0;
        while (!(rdy[1] === 1'b1 && vld[1] === 1'b0) && k < 20) begin @(negedge clk); k++; end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] gd, ed, pre; logic gf, ef; int lat, nv;
        ref_op(1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, pre, ef);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'b10; addr[1] = 32'd0; din[1] = 32'hAAAAAAAA;
        @(negedge clk);
        req[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (rdy[1] !== 1'b1) begin failures++; $display("FAIL rst_wait_ready got=%b exp=1", rdy[1]); end
        if (vld[1] !== 1'b0) begin failures++; $display("FAIL rst_wait_valid got=%b exp=0", vld[1]); end
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            if (vld[1] === 1'b1) nv++;
        end
        checks++;
        if (nv != 0) begin failures++; $display("FAIL rst_wait_no_valid got=%0d exp=0", nv); end
        op(1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, gd, gf, ed, ef, lat);
        checks++;
        if (gd !== pre || gf !== 1'b0) begin
            failures++; $display("FAIL rst_wait_no_write got=%h exp=%h", gd, pre);
        end
    endtask

    task automatic test_random();
        logic [31:0] gd, ed, a; logic gf, ef; int lat, s;
        logic [1:0] z;
        for (int i = 0; i < 120; i++) begin
            s = $urandom_range(0, 1);
            z = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 15) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, DEPTH + 4));
            op(s, 1'($urandom_range(0, 1)), z, 1'($urandom_range(0, 1)), a, $urandom,
               gd, gf, ed, ef, lat);
            checks++;
            if (gd !== ed || gf !== ef || lat != (s == 1 ? 4 : 1)) begin
                failures++;
                $display("FAIL random dut%0d size=%0d addr=%h d=%h f=%b lat=%0d exp d=%h f=%b", s, z, a, gd, gf, lat, ed, ef);
            end
        end
    endtask

    initial begin
        test_reset();
        fill_memory();
        test_word_byte();
        test_extension();
        test_misaligned();
        test_range();
        test_wait_latency();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
